// File: rtl/cdc_pkg.sv
// ---------------------------------------------------------------------------
// cdc_pkg
//   Shared definitions for the toggle req/ack clock-domain-crossing handshake.
//   This package is used by the transmit side (cdc_hs_tx) and by its matching
//   receiver.
//   Contents:
//     hs_state_e             : 2-bit handshake FSM state (FLUSH, IDLE, WAIT_ACK)
//     SYNC_STAGES_MIN/MAX    : legal range for synchronizer depth
//     TIMEOUT_CYCLES_DEFAULT : default ack-wait limit for the optional timeout
//     sync_stages_legal()    : clamps a requested depth into the legal range
// ---------------------------------------------------------------------------
package cdc_pkg;

  typedef enum logic [1:0] {
    FLUSH    = 2'd0,
    IDLE     = 2'd1,
    WAIT_ACK = 2'd2
  } hs_state_e;

  localparam int SYNC_STAGES_MIN        = 2;
  localparam int SYNC_STAGES_MAX        = 4;
  localparam int TIMEOUT_CYCLES_DEFAULT = 1024;

  // Keeps an out-of-range synchronizer depth from building a chain that is
  // too shallow to be metastability-safe or wider than the flush counter.
  function automatic int sync_stages_legal(input int stages);
    if (stages < SYNC_STAGES_MIN) begin
      return SYNC_STAGES_MIN;
    end else if (stages > SYNC_STAGES_MAX) begin
      return SYNC_STAGES_MAX;
    end else begin
      return stages;
    end
  endfunction

endpackage : cdc_pkg

// File: rtl/sync_bits.sv
// ---------------------------------------------------------------------------
// sync_bits
//   A flop chain that brings a level signal into the i_clock domain. Each bit
//   is synchronized on its own, so only use this for single-bit levels or for
//   Gray-coded buses. The receiver reuses this module for its req synchronizer.
//   Ports:
//     i_clock : destination clock
//     i_reset : synchronous, active-high reset; clears every stage to 0
//     i_d     : asynchronous input level (WIDTH bits)
//     o_q     : synchronized level, delayed by STAGES i_clock edges
// ---------------------------------------------------------------------------
module sync_bits #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] sync_d [STAGES];
  logic [WIDTH-1:0] sync_q [STAGES];

  always_comb begin
    sync_d[0] = i_d;
    for (int k = 1; k < STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int k = 0; k < STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
    end
  end

  assign o_q = sync_q[STAGES-1];

endmodule : sync_bits

// File: rtl/cdc_hs_tx.sv
// ---------------------------------------------------------------------------
// cdc_hs_tx
//   This is the source (transmit) side of a 2-phase toggle req/ack handshake.
//   It carries an NB-bit word across a clock-domain boundary. The block takes
//   a word on the valid/ready interface and holds it stable on o_data. It then
//   toggles o_req. It does not accept the next word until the synchronized
//   ack level matches o_req again.
//
//   Optional feature (macro CDC_HS_TX_TIMEOUT_EN):
//     A counter runs while the block sits in WAIT_ACK. After TIMEOUT_CYCLES
//     cycles without an ack it raises a sticky o_timeout flag. The flag stays
//     set until i_reset. When the macro is undefined, no counter is built and
//     o_timeout is tied to 0.
//
//   Ports:
//     i_clock   : source clock; all state changes on its rising edge
//     i_reset   : synchronous, active-high reset
//     i_data    : word to send (NB bits)
//     i_valid   : i_data is valid this cycle
//     o_ready   : the block can accept a word this cycle
//     o_data    : registered word seen by the destination domain
//     o_req     : request level; toggles once per transferred word
//     i_ack     : ack level from the destination; asynchronous to i_clock
//     o_busy    : a transfer is in flight
//     o_timeout : sticky ack-timeout flag
// ---------------------------------------------------------------------------
module cdc_hs_tx
  import cdc_pkg::*;
#(
  parameter int NB             = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic [NB-1:0] i_data,
  input  logic          i_valid,
  output logic          o_ready,
  output logic [NB-1:0] o_data,
  output logic          o_req,
  input  logic          i_ack,
  output logic          o_busy,
  output logic          o_timeout
);

  localparam int                 STAGES     = sync_stages_legal(SYNC_STAGES);
  localparam int                 FLUSH_W    = 3;
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(STAGES - 1);

  hs_state_e          state_d, state_q;
  logic [FLUSH_W-1:0] flush_cnt_d, flush_cnt_q;
  logic [NB-1:0]      data_d, data_q;
  logic               req_d, req_q;
  logic               ready_d, ready_q;
  logic               busy_d, busy_q;
  logic               ack_s;
  logic               accept;

  // Only ack_s is used in the logic below. The raw i_ack is never sampled
  // directly.
  sync_bits #(
    .WIDTH  (1),
    .STAGES (STAGES)
  ) u_ack_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_d     (i_ack),
    .o_q     (ack_s)
  );

  assign accept = (state_q == IDLE) && i_valid && ready_q;

  // FLUSH lets the synchronizer fill with the true ack level before the
  // block trusts it. After FLUSH the block goes through WAIT_ACK, so a
  // destination that still holds ack=1 from before a reset stalls this side.
  // It stalls until that destination resets as well.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    data_d      = data_q;
    req_d       = req_q;
    ready_d     = ready_q;
    busy_d      = busy_q;
    case (state_q)
      FLUSH: begin
        ready_d = 1'b0;
        busy_d  = 1'b0;
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d = WAIT_ACK;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          data_d  = i_data;
          req_d   = ~req_q;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_s == req_q) begin
          state_d = IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = FLUSH;
        ready_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= FLUSH;
      flush_cnt_q <= '0;
      data_q      <= '0;
      req_q       <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      data_q      <= data_d;
      req_q       <= req_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign o_data  = data_q;
  assign o_req   = req_q;
  assign o_ready = ready_q;
  assign o_busy  = busy_q;

`ifdef CDC_HS_TX_TIMEOUT_EN
  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_d, to_cnt_q;
  logic            timeout_d, timeout_q;

  // The counter holds at its last value once it has expired. The flag stays
  // set; the FSM is left alone and keeps waiting for the ack.
  always_comb begin
    to_cnt_d  = to_cnt_q;
    timeout_d = timeout_q;
    if (accept) begin
      to_cnt_d = '0;
    end else if (state_q == WAIT_ACK) begin
      if (to_cnt_q == TO_LAST) begin
        timeout_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign o_timeout          = 1'b0;
`endif

endmodule : cdc_hs_tx

// File: tb/tb_cdc_hs_tx.sv
// ---------------------------------------------------------------------------
// tb_cdc_hs_tx
//   Directed bench for cdc_hs_tx (NB=8, SYNC_STAGES=2, TIMEOUT_CYCLES=16).
//   A behavioural receiver runs on its own 7-unit clock. It synchronizes
//   o_req, samples o_data on each req toggle and answers with an ack toggle.
//   Expected words go into a queue at the moment the source offers them.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cdc_hs_tx;

  logic       i_clock = 1'b0;
  logic       rclk    = 1'b0;
  logic       i_reset;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] o_data;
  logic       o_req;
  logic       i_ack;
  logic       o_busy;
  logic       o_timeout;

  logic       man_ack  = 1'b0;
  logic       rx_en    = 1'b0;
  logic       rx_ack   = 1'b0;
  logic [1:0] rsync    = 2'b00;
  logic       prev_req = 1'b0;
  int         rx_count = 0;
  int         toggles  = 0;
  int         checks   = 0;
  int         errors   = 0;
  logic [7:0] expq[$];

  // The ack level comes from the bench when rx_en is low and from the
  // behavioural receiver when rx_en is high.
  assign i_ack = rx_en ? rx_ack : man_ack;

  cdc_hs_tx #(
    .NB             (8),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .o_data    (o_data),
    .o_req     (o_req),
    .i_ack     (i_ack),
    .o_busy    (o_busy),
    .o_timeout (o_timeout)
  );

  always #5 i_clock = ~i_clock;

  always begin
    #3 rclk = 1'b1;
    #4 rclk = 1'b0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d);
    i_valid = v;
    i_data  = d;
  endtask

  // Offers a word and waits until the source shows o_ready, within a cycle
  // budget. The word is queued because the next rising edge accepts it.
  task automatic sendWord(input logic [7:0] d, input int budget);
    bit done = 1'b0;
    applyStimulus(1'b1, d);
    for (int k = 0; k < budget; k++) begin
      if (o_ready === 1'b1) begin
        expq.push_back(d);
        @(negedge i_clock);
        done = 1'b1;
        break;
      end
      @(negedge i_clock);
    end
    applyStimulus(1'b0, 8'h00);
    if (!done) checkOutput("send_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitReady(input int budget);
    bit done = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (o_ready === 1'b1) begin
        done = 1'b1;
        break;
      end
      @(negedge i_clock);
    end
    if (!done) checkOutput("wait_ready_timeout", 32'd0, 32'd1);
  endtask

  // Behavioural destination: 2-flop req synchronizer and ack on each toggle.
  always @(posedge rclk) begin
    logic [7:0] want;
    rsync <= {rsync[0], o_req};
    if (!rx_en) begin
      rx_ack <= rsync[1];
    end else if (rsync[1] != rx_ack) begin
      if (expq.size() == 0) begin
        checkOutput("rx_unexpected_word", 32'd0, 32'd1);
      end else begin
        want = expq.pop_front();
        checkOutput("rx_word", {24'd0, o_data}, {24'd0, want});
      end
      rx_count <= rx_count + 1;
      rx_ack   <= rsync[1];
    end
  end

  always @(negedge i_clock) begin
    prev_req <= o_req;
    if (rx_en && (o_req !== prev_req)) toggles <= toggles + 1;
  end

  initial begin
    logic [7:0] want;
    i_reset = 1'b1;
    applyStimulus(1'b0, 8'h00);
    repeat (3) @(negedge i_clock);

    checkOutput("rst_ready",   {31'd0, o_ready},   32'd0);
    checkOutput("rst_req",     {31'd0, o_req},     32'd0);
    checkOutput("rst_data",    {24'd0, o_data},    32'd0);
    checkOutput("rst_busy",    {31'd0, o_busy},    32'd0);
    checkOutput("rst_timeout", {31'd0, o_timeout}, 32'd0);

    // Release the reset with i_valid high: nothing may be accepted during FLUSH
    i_reset = 1'b0;
    applyStimulus(1'b1, 8'hEE);
    for (int i = 0; i < 3; i++) begin
      checkOutput("flush_ready", {31'd0, o_ready}, 32'd0);
      checkOutput("flush_busy",  {31'd0, o_busy},  32'd0);
      if (i == 2) applyStimulus(1'b0, 8'h00);
      @(negedge i_clock);
    end
    checkOutput("up_ready", {31'd0, o_ready}, 32'd1);
    checkOutput("up_req",   {31'd0, o_req},   32'd0);
    checkOutput("up_data",  {24'd0, o_data},  32'd0);

    // First accept
    applyStimulus(1'b1, 8'hA5);
    expq.push_back(8'hA5);
    @(negedge i_clock);
    applyStimulus(1'b1, 8'h3C);
    want = expq.pop_front();
    checkOutput("acc_data",  {24'd0, o_data}, {24'd0, want});
    checkOutput("acc_req",   {31'd0, o_req},   32'd1);
    checkOutput("acc_ready", {31'd0, o_ready}, 32'd0);
    checkOutput("acc_busy",  {31'd0, o_busy},  32'd1);

    // Hold a new word while the ack is pending
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clock);
      checkOutput("hold_data",  {24'd0, o_data},  32'h0000_00A5);
      checkOutput("hold_req",   {31'd0, o_req},   32'd1);
      checkOutput("hold_ready", {31'd0, o_ready}, 32'd0);
    end

    // Ack toggle: o_ready returns exactly 3 cycles later
    man_ack = 1'b1;
    @(negedge i_clock);
    checkOutput("ack_lat1_ready", {31'd0, o_ready}, 32'd0);
    @(negedge i_clock);
    checkOutput("ack_lat2_ready", {31'd0, o_ready}, 32'd0);
    @(negedge i_clock);
    checkOutput("ack_lat3_ready", {31'd0, o_ready}, 32'd1);
    checkOutput("ack_lat3_busy",  {31'd0, o_busy},  32'd0);
    checkOutput("ack_keep_data",  {24'd0, o_data},  32'h0000_00A5);
    expq.push_back(8'h3C);
    @(negedge i_clock);
    applyStimulus(1'b0, 8'h00);
    want = expq.pop_front();
    checkOutput("second_data", {24'd0, o_data}, {24'd0, want});
    checkOutput("second_req",  {31'd0, o_req},  32'd0);
    man_ack = 1'b0;
    waitReady(20);

    // Random words streamed through the behavioural receiver
    rx_en = 1'b1;
    for (int w = 0; w < 20; w++) begin
      sendWord(8'($urandom), 200);
      repeat ($urandom_range(0, 3)) @(negedge i_clock);
    end
    for (int k = 0; k < 300; k++) begin
      if ((expq.size() == 0) && (o_ready === 1'b1)) break;
      @(negedge i_clock);
    end
    checkOutput("stream_queue_empty", expq.size(), 32'd0);
    checkOutput("stream_rx_count",    rx_count,    32'd20);
    checkOutput("stream_toggles",     toggles,     32'd20);
    checkOutput("stream_ready",       {31'd0, o_ready}, 32'd1);
    man_ack = rx_ack;
    rx_en   = 1'b0;
    @(negedge i_clock);

    // Accept a word and never ack it
    waitReady(20);
    applyStimulus(1'b1, 8'h77);
    expq.push_back(8'h77);
    @(negedge i_clock);
    applyStimulus(1'b0, 8'h00);
    want = expq.pop_front();
    checkOutput("noack_data", {24'd0, o_data}, {24'd0, want});
`ifdef CDC_HS_TX_TIMEOUT_EN
    for (int k = 1; k < 16; k++) begin
      @(negedge i_clock);
      checkOutput("timeout_early", {31'd0, o_timeout}, 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clock);
      checkOutput("timeout_set", {31'd0, o_timeout}, 32'd1);
      checkOutput("timeout_busy", {31'd0, o_busy}, 32'd1);
    end
`else
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clock);
      checkOutput("timeout_off", {31'd0, o_timeout}, 32'd0);
      checkOutput("noack_ready", {31'd0, o_ready},   32'd0);
    end
`endif

    // Reset mid-transfer while the destination holds ack=1
    man_ack = 1'b1;
    i_reset = 1'b1;
    repeat (2) @(negedge i_clock);
    checkOutput("midrst_req",     {31'd0, o_req},     32'd0);
    checkOutput("midrst_ready",   {31'd0, o_ready},   32'd0);
    checkOutput("midrst_data",    {24'd0, o_data},    32'd0);
    checkOutput("midrst_timeout", {31'd0, o_timeout}, 32'd0);
    i_reset = 1'b0;
    applyStimulus(1'b1, 8'hC3);
    for (int k = 0; k < 8; k++) begin
      @(negedge i_clock);
      checkOutput("stall_ready", {31'd0, o_ready}, 32'd0);
      checkOutput("stall_req",   {31'd0, o_req},   32'd0);
    end
    applyStimulus(1'b0, 8'h00);
    man_ack = 1'b0;
    @(negedge i_clock);
    checkOutput("release1_ready", {31'd0, o_ready}, 32'd0);
    @(negedge i_clock);
    checkOutput("release2_ready", {31'd0, o_ready}, 32'd0);
    @(negedge i_clock);
    checkOutput("release3_ready", {31'd0, o_ready}, 32'd1);
    checkOutput("release3_req",   {31'd0, o_req},   32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_cdc_hs_tx
